sprite_blitter: RTL and testbench

- Writer side of the 1-bit 320x200 framebuffer that the VGA scan-out reads at 2x scale.
- Accepts draw/erase commands for 16x16 alien/player sprites and walks each sprite row by row.
- Emits single-pixel framebuffer write strobes (x, y, data), clipped to the visible area.
- Sits between the game FSM (command source) and the framebuffer block-RAM write port; only writes when the arbiter grants the port.

---
 rtl/space_invaders_pkg.sv | 38 +++
 rtl/sprite_rom.sv | 18 +
 rtl/sprite_blitter.sv | 142 ++++++++++++++
 tb/tb_sprite_blitter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/space_invaders_pkg.sv
// Shared definitions for the space-invaders video datapath: sprite ids,
// framebuffer geometry, blitter state encoding and the sprite bitmap rule.
`timescale 1ns/1ps
package space_invaders_pkg;

    localparam int FB_W_DEF    = 320;
    localparam int FB_H_DEF    = 200;
    localparam int SPRITE_SIZE = 16;

    localparam logic [1:0] SPRITE_BIG_ALIEN   = 2'd0;
    localparam logic [1:0] SPRITE_MID_ALIEN   = 2'd1;
    localparam logic [1:0] SPRITE_SMALL_ALIEN = 2'd2;
    localparam logic [1:0] SPRITE_PLAYER      = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } blit_state_e;

    // Bitmap of one sprite row: bit c is set when column c is drawn.
    function automatic logic [15:0] sprite_row_bits(input logic [1:0] sprite,
                                                    input logic [3:0] row);
        logic [15:0] bits;
        bits = '0;
        for (int c = 0; c < SPRITE_SIZE; c++) begin
            unique case (sprite)
                SPRITE_BIG_ALIEN:   bits[c] = (row >= 4'd8)  && (c < 12);
                SPRITE_MID_ALIEN:   bits[c] = (row >= 4'd8)  && (c < 11);
                SPRITE_SMALL_ALIEN: bits[c] = (row >= 4'd8)  && (c < 8);
                default:            bits[c] = (row >= 4'd12) && (c < 13);
            endcase
        end
        return bits;
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Registered sprite bitmap ROM, one 16-bit row per read, 1-cycle latency.
// Shared with the game module's collision logic.
`timescale 1ns/1ps
module sprite_rom
    import space_invaders_pkg::*;
(
    input  logic        clk,
    input  logic [1:0]  sprite,
    input  logic [3:0]  row,
    output logic [15:0] bits
);

    // Synchronous read: the addressed row appears on bits after the next edge.
    always_ff @(posedge clk) begin
        bits <= sprite_row_bits(sprite, row);
    end

endmodule

// File: rtl/sprite_blitter.sv
// Walks a 16x16 sprite row by row and emits clipped single-pixel framebuffer
// writes, stalling only on drawable pixels while the write port is not granted.
`timescale 1ns/1ps
module sprite_blitter
    import space_invaders_pkg::*;
#(
    parameter int FB_W = FB_W_DEF,
    parameter int FB_H = FB_H_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [8:0] cmd_x,
    input  logic [7:0] cmd_y,
    input  logic [1:0] cmd_sprite,
    input  logic       cmd_erase,
    input  logic       fb_grant,
    output logic       fb_we,
    output logic [8:0] fb_x,
    output logic [7:0] fb_y,
    output logic       fb_data,
    output logic       busy,
    output logic       done
);

    localparam logic [9:0] FB_W_L = 10'(FB_W);
    localparam logic [8:0] FB_H_L = 9'(FB_H);

    blit_state_e state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [1:0]  spr_q, spr_d;
    logic        erase_q, erase_d;

    logic [15:0] rowbits;
    logic [9:0]  px;
    logic [8:0]  py;
    logic        writable;
    logic        stall;

    sprite_rom u_rom (
        .clk    (clk),
        .sprite (spr_q),
        .row    (row_q),
        .bits   (rowbits)
    );

    // Pixel coordinates are formed one bit wider so off-screen positions never wrap.
    always_comb begin
        px       = {1'b0, x_q} + {6'd0, col_q};
        py       = {1'b0, y_q} + {5'd0, row_q};
        writable = rowbits[col_q] && (px < FB_W_L) && (py < FB_H_L);
        stall    = (state_q == DRAW) && writable && !fb_grant;
    end

    // State, walk counters and latched command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            spr_q   <= '0;
            erase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            x_q     <= x_d;
            y_q     <= y_d;
            spr_q   <= spr_d;
            erase_q <= erase_d;
        end
    end

    // Next-state logic and outputs.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        x_d       = x_q;
        y_d       = y_q;
        spr_d     = spr_q;
        erase_d   = erase_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        fb_we     = 1'b0;
        fb_data   = 1'b0;
        fb_x      = px[8:0];
        fb_y      = py[7:0];

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    spr_d   = cmd_sprite;
                    erase_d = cmd_erase;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // ROM is addressed by row_q this cycle; bits are valid in DRAW.
                col_d   = '0;
                state_d = DRAW;
            end
            DRAW: begin
                fb_we   = writable && fb_grant;
                fb_data = !erase_q;
                if (!stall) begin
                    if (col_q == 4'd15) begin
                        if (row_q == 4'd15) begin
                            state_d = DONE;
                        end else begin
                            row_d   = row_q + 4'd1;
                            state_d = FETCH;
                        end
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a sequential reference model predicts
// every strobe (position, data, cycle) and the done cycle for each command.
`timescale 1ns/1ps
module tb_sprite_blitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [8:0] cmd_x = '0;
    logic [7:0] cmd_y = '0;
    logic [1:0] cmd_sprite = '0;
    logic       cmd_erase = 1'b0;
    logic       fb_grant = 1'b1;
    logic       fb_we;
    logic [8:0] fb_x;
    logic [7:0] fb_y;
    logic       fb_data;
    logic       busy;
    logic       done;

    sprite_blitter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_sprite (cmd_sprite),
        .cmd_erase  (cmd_erase),
        .fb_grant   (fb_grant),
        .fb_we      (fb_we),
        .fb_x       (fb_x),
        .fb_y       (fb_y),
        .fb_data    (fb_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int d;
        int cyc;
    } exp_t;

    localparam int GLEN = 4096;

    exp_t exp_q[$];
    int   done_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   strobes = 0;
    bit   done_seen = 1'b0;
    bit   grant_seq[GLEN];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Sprite shapes straight from the bitmap rules.
    function automatic bit spr_bit(input int s, input int r, input int c);
        case (s)
            0:       return (r >= 8)  && (c < 12);
            1:       return (r >= 8)  && (c < 11);
            2:       return (r >= 8)  && (c < 8);
            default: return (r >= 12) && (c < 13);
        endcase
    endfunction

    // Timeline model: cycle 1 is the first FETCH; every row is one fetch cycle
    // plus one cycle per column, plus one extra cycle per denied grant on a
    // drawable pixel. Returns the number of strobes predicted.
    function automatic int model(input int x, input int y, input int s, input int e);
        int t = 1;
        int n = 0;
        for (int r = 0; r < 16; r++) begin
            t++;
            for (int c = 0; c < 16; c++) begin
                if (spr_bit(s, r, c) && (x + c < 320) && (y + r < 200)) begin
                    exp_t ex;
                    while (!grant_seq[t]) t++;
                    ex.x = x + c;
                    ex.y = y + r;
                    ex.d = e ? 0 : 1;
                    ex.cyc = t;
                    exp_q.push_back(ex);
                    n++;
                end
                t++;
            end
        end
        done_q.push_back(t);
        return n;
    endfunction

    task automatic set_grants(input bit rnd);
        for (int i = 0; i < GLEN; i++)
            grant_seq[i] = (rnd && i < 1500) ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // Monitor: every strobe and done pulse is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fb_we) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_unexpected: got (%0d,%0d) at cycle %0d, expected none",
                             fb_x, fb_y, cyc);
                end else begin
                    exp_t ex;
                    ex = exp_q.pop_front();
                    check("strobe_x", int'(fb_x), ex.x);
                    check("strobe_y", int'(fb_y), ex.y);
                    check("strobe_data", int'(fb_data), ex.d);
                    check("strobe_cycle", cyc, ex.cyc);
                end
            end
            if (done) begin
                done_seen = 1'b1;
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    // Issue one command; optionally inject a second command at inj_at or
    // pull reset at rst_at (0 disables either).
    task automatic run_cmd(input int x, input int y, input int s, input int e,
                           input int inj_at, input int rst_at);
        int n_exp;
        int s0;
        n_exp = model(x, y, s, e);
        s0 = strobes;
        @(negedge clk);
        check("ready_idle", int'(cmd_ready), 1);
        cmd_x = 9'(x);
        cmd_y = 8'(y);
        cmd_sprite = 2'(s);
        cmd_erase = e[0];
        cmd_valid = 1'b1;
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cyc = 1;
        fb_grant = grant_seq[1];
        check("busy_after_accept", int'(busy), 1);
        check("ready_after_accept", int'(cmd_ready), 0);
        while (!done_seen && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            fb_grant = grant_seq[cyc];
            if (cyc == inj_at) begin
                cmd_x = 9'd0;
                cmd_y = 8'd0;
                cmd_sprite = 2'(s + 1);
                cmd_erase = 1'b0;
                cmd_valid = 1'b1;
                check("ready_while_busy", int'(cmd_ready), 0);
            end
            if (inj_at != 0 && cyc == inj_at + 1) cmd_valid = 1'b0;
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_fb_we", int'(fb_we), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_ready", int'(cmd_ready), 1);
                exp_q.delete();
                done_q.delete();
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                fb_grant = 1'b1;
                check("ready_after_rst", int'(cmd_ready), 1);
                s0 = strobes;
                repeat (20) @(posedge clk);
                #1;
                check("no_strobes_after_rst", strobes - s0, 0);
                check("busy_after_rst", int'(busy), 0);
                return;
            end
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected cycle %0d",
                     cyc, (done_q.size() != 0) ? done_q[0] : -1);
            exp_q.delete();
            done_q.delete();
        end
        check("busy_after_done", int'(busy), 0);
        check("ready_after_done", int'(cmd_ready), 1);
        check("strobe_count", strobes - s0, n_exp);
        check("scoreboard_empty", exp_q.size(), 0);
        fb_grant = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_we", int'(fb_we), 0);
        check("reset_x", int'(fb_x), 0);
        check("reset_y", int'(fb_y), 0);
        check("reset_data", int'(fb_data), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        set_grants(1'b0);
        run_cmd(4, 20, 2, 0, 0, 0);          // small alien, 64 strobes
        run_cmd(310, 190, 0, 0, 0, 0);       // big alien clipped to 20 strobes
        run_cmd(100, 50, 1, 1, 0, 0);        // erase mid alien, 88 strobes

        for (int i = 138; i < 143; i++) grant_seq[i] = 1'b0;
        run_cmd(0, 0, 2, 0, 0, 0);           // stalled first pixel, done at 278
        set_grants(1'b0);

        run_cmd(50, 60, 0, 0, 10, 0);        // second command ignored while busy
        run_cmd(20, 30, 3, 0, 0, 1 + 17 * 10 + 5);  // reset mid row 10
        run_cmd(4, 20, 2, 0, 0, 0);          // clean command after reset

        for (int k = 0; k < 6; k++) begin
            set_grants(1'b1);
            run_cmd($urandom_range(0, 511), $urandom_range(0, 255),
                    $urandom_range(0, 3), $urandom_range(0, 1), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
